// File: rtl/arm_pkg.sv
// Shared widths and constants for the ARM data-processing datapath.
package arm_pkg;
  localparam int WORD_W  = 32;
  localparam int IMM8_W  = 8;
  localparam int ROT_W   = 4;
  localparam int SHAMT_W = 5;

  localparam logic [WORD_W-1:0] WORD_ZERO = '0;

  function automatic logic [WORD_W-1:0] zext_imm8(input logic [IMM8_W-1:0] imm);
    return {{(WORD_W-IMM8_W){1'b0}}, imm};
  endfunction
endpackage

// File: rtl/barrel_ror32.sv
// Combinational 32-bit rotate-right built from log2 stages (1/2/4/8/16).
module barrel_ror32
  import arm_pkg::*;
(
  input  logic [WORD_W-1:0]  data,
  input  logic [SHAMT_W-1:0] amount,
  output logic [WORD_W-1:0]  result
);

  logic [WORD_W-1:0] stage [0:SHAMT_W];

  assign stage[0] = data;

  // Stage gi rotates by 2**gi when its amount bit is set.
  generate
    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      assign stage[gi+1] = amount[gi]
                         ? {stage[gi][SH-1:0], stage[gi][WORD_W-1:SH]}
                         : stage[gi];
    end
  endgenerate

  assign result = stage[SHAMT_W];

endmodule

// File: rtl/right_rotator_32.sv
// Registered ARM immediate-operand rotator: ROR(zext(imm8), 2*rotate_imm)
// plus shifter carry-out, loaded on EN.
module right_rotator_32
  import arm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EN,
  input  logic              CarryFlag,
  input  logic [IMM8_W-1:0] immediate,
  input  logic [ROT_W-1:0]  rotate_imm,
  output logic [WORD_W-1:0] Y,
  output logic              Carry
);

  logic [WORD_W-1:0] ext;
  logic [WORD_W-1:0] rot;
  logic              carry_next;

  assign ext = zext_imm8(immediate);

  barrel_ror32 u_ror (
    .data   (ext),
    .amount ({rotate_imm, 1'b0}),
    .result (rot)
  );

  // A zero rotate leaves the C flag untouched; otherwise carry is the new MSB.
  always_comb begin
    carry_next = rot[WORD_W-1];
    if (rotate_imm == '0) begin
      carry_next = CarryFlag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y     <= WORD_ZERO;
      Carry <= 1'b0;
    end else if (EN) begin
      Y     <= rot;
      Carry <= carry_next;
    end
  end

endmodule

// File: tb/tb_right_rotator_32.sv
// Directed-vector bench for right_rotator_32 with hand-computed expectations.
module tb_right_rotator_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EN;
  logic        CarryFlag;
  logic [7:0]  immediate;
  logic [3:0]  rotate_imm;
  logic [31:0] Y;
  logic        Carry;

  int checks = 0;
  int errors = 0;

  right_rotator_32 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .EN         (EN),
    .CarryFlag  (CarryFlag),
    .immediate  (immediate),
    .rotate_imm (rotate_imm),
    .Y          (Y),
    .Carry      (Carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 0x0A rotated right by 2*r, r = 0..15
  logic [31:0] sweep_y [16] = '{
    32'h0000000A, 32'h80000002, 32'hA0000000, 32'h28000000,
    32'h0A000000, 32'h02800000, 32'h00A00000, 32'h00280000,
    32'h000A0000, 32'h00028000, 32'h0000A000, 32'h00002800,
    32'h00000A00, 32'h00000280, 32'h000000A0, 32'h00000028
  };
  logic sweep_c [16] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    rst_n = 1'b0; EN = 1'b1; CarryFlag = 1'b1;
    immediate = 8'hFF; rotate_imm = 4'd1;
    #1 immediate = 8'h5A; rotate_imm = 4'd7; CarryFlag = 1'b0;
    #1 immediate = 8'hA5; CarryFlag = 1'b1;
    #1;
    check("reset_y", Y, 32'h0);
    check("reset_c", {31'b0, Carry}, 32'h0);
    step();
    check("reset_y_edge", Y, 32'h0);
    check("reset_c_edge", {31'b0, Carry}, 32'h0);
    rst_n = 1'b1;

    // Sweep all rotate amounts
    immediate = 8'h0A; CarryFlag = 1'b1; EN = 1'b1;
    for (int r = 0; r < 16; r++) begin
      rotate_imm = 4'(r);
      step();
      check($sformatf("sweep_y_r%0d", r), Y, sweep_y[r]);
      check($sformatf("sweep_c_r%0d", r), {31'b0, Carry}, {31'b0, sweep_c[r]});
    end

    // Hold while EN low; CarryFlag change must not leak into held Carry
    rotate_imm = 4'd2;
    step();
    check("hold_load_y", Y, 32'hA0000000);
    EN = 1'b0;
    for (int k = 0; k < 7; k++) begin
      rotate_imm = 4'(3 + k);
      CarryFlag  = k[0];
      immediate  = (k == 3) ? 8'hFF : 8'h0A;
      step();
      check($sformatf("hold_y_%0d", k), Y, 32'hA0000000);
      check($sformatf("hold_c_%0d", k), {31'b0, Carry}, 32'h1);
    end
    immediate = 8'h0A; rotate_imm = 4'd10; CarryFlag = 1'b1; EN = 1'b1;
    step();
    check("reen_y", Y, 32'h0000A000);
    check("reen_c", {31'b0, Carry}, 32'h0);

    // Carry passthrough at rotate 0
    immediate = 8'hFF; rotate_imm = 4'd0;
    for (int k = 0; k < 4; k++) begin
      CarryFlag = k[0];
      step();
      check($sformatf("pass_y_%0d", k), Y, 32'h000000FF);
      check($sformatf("pass_c_%0d", k), {31'b0, Carry}, {31'b0, k[0]});
    end

    // Wrap cases
    immediate = 8'hC1; rotate_imm = 4'd15; CarryFlag = 1'b1;
    step();
    check("wrap15_y", Y, 32'h00000304);
    check("wrap15_c", {31'b0, Carry}, 32'h0);
    immediate = 8'h01; rotate_imm = 4'd1;
    step();
    check("wrap1_y", Y, 32'h40000000);
    check("wrap1_c", {31'b0, Carry}, 32'h0);
    immediate = 8'h80; rotate_imm = 4'd4;
    step();
    check("msb_y", Y, 32'h80000000);
    check("msb_c", {31'b0, Carry}, 32'h1);

    // Zero immediate with nonzero rotate
    immediate = 8'h00; rotate_imm = 4'd9; CarryFlag = 1'b1;
    step();
    check("zero_y", Y, 32'h0);
    check("zero_c", {31'b0, Carry}, 32'h0);

    // Mid-operation asynchronous reset
    immediate = 8'h0A; rotate_imm = 4'd1; CarryFlag = 1'b0;
    step();
    check("mid_load_y", Y, 32'h80000002);
    check("mid_load_c", {31'b0, Carry}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_y", Y, 32'h0);
    check("mid_rst_c", {31'b0, Carry}, 32'h0);
    #2 rst_n = 1'b1;
    step();
    check("mid_reload_y", Y, 32'h80000002);
    check("mid_reload_c", {31'b0, Carry}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
